async_fifo: RTL and testbench

Single-clock, parameterised first-in/first-out buffer, 140 bits wide and 2 entries deep by default. It decouples a producer and a consumer that share one clock domain, giving write/read enables with full/empty status. The module keeps the `async_fifo` name and the `clk_in`/`rst_n` port naming used across the codebase; there is no second clock and no clock-domain crossing logic.

---
 rtl/async_fifo.sv | 71 +++++++
 tb/tb_async_fifo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with full/empty status and a registered read port.
// The module name is historical; there is one clock domain and no CDC logic.
module async_fifo #(
  parameter int unsigned DW    = 140,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          fifo_w_enable,
  input  logic [DW-1:0] data_to_fifo,
  input  logic          fifo_r_enable,
  output logic [DW-1:0] data_from_fifo,
  output logic          fifo_full,
  output logic          fifo_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          wr_acc;
  logic          rd_acc;

  assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
  assign fifo_full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                          (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign data_from_fifo = rd_data_q;

  // Accept each side against pre-edge flags; compute next pointers, storage and read data.
  always_comb begin
    wr_acc    = fifo_w_enable && !fifo_full;
    rd_acc    = fifo_r_enable && !fifo_empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    mem_d     = mem_q;
    if (wr_acc) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_to_fifo;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
  end

  // Pointer and read-data registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are not cleared by reset and writes are blocked while in reset.
  always_ff @(posedge clk_in) begin
    if (rst_n) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: scoreboard bench for async_fifo against a queue-based reference model.
module tb_async_fifo;

  localparam int unsigned DW    = 140;
  localparam int unsigned DEPTH = 2;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          fifo_w_enable;
  logic [DW-1:0] data_to_fifo;
  logic          fifo_r_enable;
  logic [DW-1:0] data_from_fifo;
  logic          fifo_full;
  logic          fifo_empty;

  async_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .fifo_w_enable  (fifo_w_enable),
    .data_to_fifo   (data_to_fifo),
    .fifo_r_enable  (fifo_r_enable),
    .data_from_fifo (data_from_fifo),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: the FIFO contents as a queue, plus the last popped word.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_last;
  // Scoreboard: words the DUT must present after an accepted read.
  logic [DW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            n_vec  = 0;
  int            n_bad  = 0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  // Apply one clock of stimulus and advance the model by the same edge.
  task automatic step(input bit rst, input bit we, input logic [DW-1:0] wd, input bit re);
    bit r_ok;
    bit w_ok;
    rst_n         = rst;
    fifo_w_enable = we;
    data_to_fifo  = wd;
    fifo_r_enable = re;
    @(posedge clk_in);
    if (!rst) begin
      model_q.delete();
      exp_q.delete();
      model_last = '0;
    end else begin
      r_ok = re && (model_q.size() != 0);
      w_ok = we && (model_q.size() < DEPTH);
      if (r_ok) begin
        model_last = model_q.pop_front();
        exp_q.push_back(model_last);
      end
      if (w_ok) model_q.push_back(wd);
    end
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  // Monitor: away from the active edge, check flags against model occupancy and
  // data against the scoreboard (popped word after a read, held word otherwise).
  always @(negedge clk_in) begin
    logic [DW-1:0] exp_d;
    if (mon_en) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : model_last;
      n_vec++;
      if (data_from_fifo !== exp_d) begin
        n_bad++;
        $display("FAIL data t=%0t: got %h expected %h", $time, data_from_fifo, exp_d);
      end
      n_vec++;
      if (fifo_full !== (model_q.size() == DEPTH)) begin
        n_bad++;
        $display("FAIL full t=%0t: got %b expected %b", $time, fifo_full, model_q.size() == DEPTH);
      end
      n_vec++;
      if (fifo_empty !== (model_q.size() == 0)) begin
        n_bad++;
        $display("FAIL empty t=%0t: got %b expected %b", $time, fifo_empty, model_q.size() == 0);
      end
    end
  end

  initial begin
    logic [DW-1:0] w;
    model_last = '0;
    // Reset, then fill with 1 and 2 and idle: full.
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, rand_word(), 1'b1);
    step(1'b1, 1'b1, DW'(1), 1'b0);
    step(1'b1, 1'b1, DW'(2), 1'b0);
    idle(2);
    // Drain: 1 then 2, then empty.
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    idle(2);
    // Fill, then hold reset 4 cycles with enables active; read after reset keeps 0.
    step(1'b1, 1'b1, DW'(5), 1'b0);
    step(1'b1, 1'b1, DW'(6), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_word(), 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    // Data present without enable is ignored; then write/read A5A5A5A5.
    step(1'b1, 1'b0, DW'(32'h1234), 1'b0);
    step(1'b1, 1'b1, DW'(32'hA5A5A5A5), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    // Overflow: write 3 while full is dropped; reads return 1 then 2.
    step(1'b1, 1'b1, DW'(1), 1'b0);
    step(1'b1, 1'b1, DW'(2), 1'b0);
    step(1'b1, 1'b1, DW'(3), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    // Underflow: read while empty holds data.
    step(1'b1, 1'b0, '0, 1'b1);
    // Simultaneous read/write at full and at empty.
    step(1'b1, 1'b1, DW'(7), 1'b1);
    step(1'b1, 1'b1, DW'(8), 1'b0);
    step(1'b1, 1'b1, DW'(9), 1'b1);
    step(1'b1, 1'b1, DW'(10), 1'b1);
    idle(1);
    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      w = rand_word();
      step(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1, w, $urandom_range(0, 1) == 1);
    end
    idle(2);
    @(negedge clk_in);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
